// File: rtl/invader_fleet_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : invader_fleet_ctrl                                           |
// | Description : Invader row controller. Marches the row, detects bullet hits, |
// |               and flags level-clear / game-over.                           |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module invader_fleet_ctrl #(
  parameter int NUM_INVADERS   = 10,
  parameter int Y_INIT         = 100,
  parameter int INVADER_WIDTH  = 64,
  parameter int INVADER_HEIGHT = 48,
  parameter int STEP_X         = 8,
  parameter int STEP_Y         = 16,
  parameter int MOVE_PERIOD    = 30,
  parameter int MIN_PERIOD     = 4,
  parameter int LEFT_LIMIT     = 16,
  parameter int RIGHT_LIMIT    = 1008,
  parameter int BOTTOM_LIMIT   = 700
) (
  input  logic                               clk65MHz,
  input  logic                               rst,
  input  logic                               frame_tick,
  input  logic                               restart,
  input  logic [NUM_INVADERS-1:0][11:0]      invader_x_positions,
  input  logic [11:0]                        bullet_x,
  input  logic [11:0]                        bullet_y,
  input  logic                               bullet_active,
  output logic [9:0]                         xpos,
  output logic [9:0]                         ypos,
  output logic [NUM_INVADERS-1:0]            invader_enable,
  output logic                               bullet_hit,
  output logic [3:0]                         hit_index,
  output logic                               all_destroyed,
  output logic                               game_over
);

  localparam int                 c_CNT_W       = 16;
  localparam logic [12:0]        c_W13         = 13'(INVADER_WIDTH);
  localparam logic [12:0]        c_H13         = 13'(INVADER_HEIGHT);
  localparam logic [12:0]        c_Y_INIT13    = 13'(Y_INIT);
  localparam logic [12:0]        c_STEP_X13    = 13'(STEP_X);
  localparam logic [12:0]        c_LEFT13      = 13'(LEFT_LIMIT);
  localparam logic [12:0]        c_RIGHT13     = 13'(RIGHT_LIMIT);
  localparam logic [12:0]        c_BOTTOM13    = 13'(BOTTOM_LIMIT);
  localparam logic [9:0]         c_STEP_X10    = 10'(STEP_X);
  localparam logic [10:0]        c_STEP_Y11    = 11'(STEP_Y);
  localparam logic [c_CNT_W-1:0] c_MOVE_PERIOD = c_CNT_W'(MOVE_PERIOD);
  localparam logic [c_CNT_W-1:0] c_MIN_PERIOD  = c_CNT_W'(MIN_PERIOD);

  typedef enum logic [2:0] {
    S_WAIT      = 3'd0,
    S_EVAL      = 3'd1,
    S_STEP_H    = 3'd2,
    S_STEP_DOWN = 3'd3,
    S_HALT      = 3'd4
  } state_t;

  state_t                    r_state;
  logic [c_CNT_W-1:0]        r_frame_cnt;
  logic                      r_dir_right;
  logic                      r_armed;
  logic [9:0]                r_xpos;
  logic [9:0]                r_ypos;
  logic [NUM_INVADERS-1:0]   r_enable;
  logic                      r_bullet_hit;
  logic [3:0]                r_hit_index;
  logic                      r_all_destroyed;
  logic                      r_game_over;

  state_t                    w_state_nxt;
  logic [c_CNT_W-1:0]        w_cnt_nxt;
  logic [9:0]                w_xpos_nxt;
  logic [9:0]                w_ypos_nxt;
  logic                      w_dir_nxt;
  logic [10:0]               w_y_sum;
  logic [c_CNT_W-1:0]        w_dead_cnt;
  logic [c_CNT_W-1:0]        w_period;
  logic [12:0]               w_lmin;
  logic [12:0]               w_rmax;
  logic [12:0]               w_row_top;
  logic [12:0]               w_row_bot;
  logic [12:0]               w_bx;
  logic [12:0]               w_by;
  logic                      w_in_row;
  logic [NUM_INVADERS-1:0]   w_hit_vec;
  logic [NUM_INVADERS-1:0]   w_kill_onehot;
  logic                      w_hit_any;
  logic [3:0]                w_hit_idx;
  logic                      w_none_alive;
  logic                      w_bottom_reached;

  always_comb begin
    w_dead_cnt = '0;
    for (int i = 0; i < NUM_INVADERS; i++) begin
      w_dead_cnt = w_dead_cnt + {{(c_CNT_W-1){1'b0}}, ~r_enable[i]};
    end
  end

  assign w_period = (w_dead_cnt + c_MIN_PERIOD >= c_MOVE_PERIOD) ? c_MIN_PERIOD
                                                                 : c_MOVE_PERIOD - w_dead_cnt;

  // Row extent over live invaders only; dead sprites must not hold the row back.
  always_comb begin
    w_lmin = 13'h1FFF;
    w_rmax = '0;
    for (int i = 0; i < NUM_INVADERS; i++) begin
      if (r_enable[i]) begin
        if ({1'b0, invader_x_positions[i]} < w_lmin) begin
          w_lmin = {1'b0, invader_x_positions[i]};
        end
        if ({1'b0, invader_x_positions[i]} + c_W13 > w_rmax) begin
          w_rmax = {1'b0, invader_x_positions[i]} + c_W13;
        end
      end
    end
  end

  assign w_row_top        = c_Y_INIT13 + {3'b000, r_ypos};
  assign w_row_bot        = w_row_top + c_H13;
  assign w_bx             = {1'b0, bullet_x};
  assign w_by             = {1'b0, bullet_y};
  assign w_in_row         = (w_by >= w_row_top) && (w_by < w_row_bot);
  assign w_none_alive     = (r_enable == '0);
  assign w_bottom_reached = (w_row_bot >= c_BOTTOM13);

  for (genvar gi = 0; gi < NUM_INVADERS; gi++) begin : g_hit
    logic [12:0] w_x_lo;
    assign w_x_lo        = {1'b0, invader_x_positions[gi]};
    assign w_hit_vec[gi] = bullet_active & r_armed & r_enable[gi] & w_in_row &
                           (w_bx >= w_x_lo) & (w_bx < w_x_lo + c_W13);
  end

  // Scanning downwards leaves the lowest matching index as the winner.
  always_comb begin
    w_hit_any     = 1'b0;
    w_hit_idx     = '0;
    w_kill_onehot = '0;
    for (int i = NUM_INVADERS - 1; i >= 0; i--) begin
      if (w_hit_vec[i]) begin
        w_hit_any        = 1'b1;
        w_hit_idx        = 4'(i);
        w_kill_onehot    = '0;
        w_kill_onehot[i] = 1'b1;
      end
    end
  end

  assign w_y_sum = {1'b0, r_ypos} + c_STEP_Y11;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_frame_cnt;
    w_xpos_nxt  = r_xpos;
    w_ypos_nxt  = r_ypos;
    w_dir_nxt   = r_dir_right;
    case (r_state)
      S_WAIT: begin
        if (frame_tick) begin
          if (r_frame_cnt + 1'b1 >= w_period) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_EVAL;
          end else begin
            w_cnt_nxt = r_frame_cnt + 1'b1;
          end
        end
      end
      // The offset register updates on the EVAL edge; the STEP states only mark it.
      S_EVAL: begin
        if (r_dir_right) begin
          w_state_nxt = (w_rmax + c_STEP_X13 > c_RIGHT13) ? S_STEP_DOWN : S_STEP_H;
        end else begin
          w_state_nxt = ((w_lmin < c_LEFT13 + c_STEP_X13) || (r_xpos < c_STEP_X10))
                        ? S_STEP_DOWN : S_STEP_H;
        end
        if (w_state_nxt == S_STEP_H) begin
          w_xpos_nxt = r_dir_right ? r_xpos + c_STEP_X10 : r_xpos - c_STEP_X10;
        end else begin
          w_ypos_nxt = w_y_sum[10] ? 10'h3FF : w_y_sum[9:0];
          w_dir_nxt  = ~r_dir_right;
        end
      end
      S_STEP_H, S_STEP_DOWN: w_state_nxt = S_WAIT;
      S_HALT:                w_state_nxt = S_HALT;
      default:               w_state_nxt = S_WAIT;
    endcase
    // An empty mask also halts so EVAL never sees an empty row.
    if (r_all_destroyed || r_game_over || w_none_alive) begin
      w_state_nxt = S_HALT;
      w_cnt_nxt   = r_frame_cnt;
      w_xpos_nxt  = r_xpos;
      w_ypos_nxt  = r_ypos;
      w_dir_nxt   = r_dir_right;
    end
  end

  always_ff @(posedge clk65MHz) begin
    if (rst || restart) begin
      r_state         <= S_WAIT;
      r_frame_cnt     <= '0;
      r_dir_right     <= 1'b1;
      r_armed         <= 1'b1;
      r_xpos          <= '0;
      r_ypos          <= '0;
      r_enable        <= '1;
      r_bullet_hit    <= 1'b0;
      r_hit_index     <= '0;
      r_all_destroyed <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_cnt  <= w_cnt_nxt;
      r_dir_right  <= w_dir_nxt;
      r_xpos       <= w_xpos_nxt;
      r_ypos       <= w_ypos_nxt;
      r_bullet_hit <= w_hit_any;
      if (w_hit_any) begin
        r_enable    <= r_enable & ~w_kill_onehot;
        r_hit_index <= w_hit_idx;
        r_armed     <= 1'b0;
      end else if (!bullet_active) begin
        r_armed <= 1'b1;
      end
      if (w_none_alive) begin
        r_all_destroyed <= 1'b1;
      end
      if (w_bottom_reached) begin
        r_game_over <= 1'b1;
      end
    end
  end

  assign xpos           = r_xpos;
  assign ypos           = r_ypos;
  assign invader_enable = r_enable;
  assign bullet_hit     = r_bullet_hit;
  assign hit_index      = r_hit_index;
  assign all_destroyed  = r_all_destroyed;
  assign game_over      = r_game_over;

endmodule
`default_nettype wire
